// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a registered-read FIFO into a valid/ready stream
// through a 3-entry elastic buffer, framing bursts of BURST_LEN beats with m_last.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [31:0]           beat_count
);

  localparam int DEPTH = 3;
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_q [DEPTH];
  logic [1:0]            head_q;
  logic [1:0]            tail_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic                  rd_pending_q;
  logic [CNT_W-1:0]      beat_cnt_q;
  logic [31:0]           beat_count_q;
  logic [2:0]            credit_used;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // The in-flight read already owns a slot, so registered FIFO data always lands;
  // m_ready is deliberately kept out of the read request.
  assign credit_used = {1'b0, count_q} + {2'b00, rd_pending_q};
  assign fifo_rd_en  = en & ~fifo_empty & (credit_used < 3'(DEPTH));
  assign fifo_cs     = fifo_rd_en;

  assign push       = rd_pending_q;
  assign pop        = m_valid & m_ready;
  assign m_valid    = (count_q != 2'd0);
  assign m_data     = buf_q[head_q];
  assign m_last     = m_valid & (beat_cnt_q == LAST_BEAT);
  assign busy       = rd_pending_q | m_valid;
  assign beat_count = beat_count_q;

  // NOTE: count_d gets its default before the case, so no path through the block
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: ;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every update at the edge
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      rd_pending_q <= 1'b0;
      beat_cnt_q   <= '0;
      beat_count_q <= '0;
    end else begin
      rd_pending_q <= fifo_rd_en;
      count_q      <= count_d;
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop) begin
        head_q       <= ptr_inc(head_q);
        beat_count_q <= beat_count_q + 32'd1;
        beat_cnt_q   <= (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: the data entries are reset so m_data reads 0 straight out of reset;
  // afterwards only the tail slot is written, so the head stays stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (push) begin
      buf_q[tail_q] <= fifo_data_out;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: BURST_LEN=4 and BURST_LEN=1 instances, each fed by
// a depth-8 registered-read FIFO model, with a scoreboard checking every beat.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       en_s, m_ready_s, f_empty, rd_en, cs, m_valid, m_last, busy, w_en;
  logic [1:0][31:0] f_dout, m_data, beat_count, w_data;

  fifo_stream_reader #(.DATA_WIDTH(32), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en_s[0]), .fifo_empty(f_empty[0]),
    .fifo_data_out(f_dout[0]), .fifo_cs(cs[0]), .fifo_rd_en(rd_en[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready_s[0]), .m_data(m_data[0]),
    .m_last(m_last[0]), .busy(busy[0]), .beat_count(beat_count[0])
  );

  fifo_stream_reader #(.DATA_WIDTH(32), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en_s[1]), .fifo_empty(f_empty[1]),
    .fifo_data_out(f_dout[1]), .fifo_cs(cs[1]), .fifo_rd_en(rd_en[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready_s[1]), .m_data(m_data[1]),
    .m_last(m_last[1]), .busy(busy[1]), .beat_count(beat_count[1])
  );

  // FIFO models: rd_en with !empty updates f_dout at the edge; writes from the bench.
  logic [31:0] fm [2][8];
  int          fcnt [2];
  logic [2:0]  wp [2];
  logic [2:0]  rp [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        fcnt[g] <= 0; wp[g] <= '0; rp[g] <= '0; f_dout[g] <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (rd_en[g] && fcnt[g] != 0) begin
          f_dout[g] <= fm[g][rp[g]];
          rp[g]     <= rp[g] + 3'd1;
        end
        if (w_en[g] && fcnt[g] != 8) begin
          fm[g][wp[g]] <= w_data[g];
          wp[g]        <= wp[g] + 3'd1;
        end
        fcnt[g] <= fcnt[g] + ((w_en[g] && fcnt[g] != 8) ? 1 : 0)
                           - ((rd_en[g] && fcnt[g] != 0) ? 1 : 0);
      end
    end
  end

  always_comb begin
    f_empty = '0;
    for (int g = 0; g < 2; g++) f_empty[g] = (fcnt[g] == 0);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act === exp, act, exp);
  endtask

  // Scoreboard: words pushed when written into a FIFO, popped on each handshake.
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  function automatic int qsize(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  int          occ [2];
  int          beat_idx [2];
  int          last_cnt [2];
  logic        prev_stall [2];
  logic [31:0] prev_data [2];
  logic        prev_last [2];
  logic [31:0] mon_exp;
  int          mon_bl;
  bit          mon_last;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        occ[g] = 0; beat_idx[g] = 0; last_cnt[g] = 0; prev_stall[g] = 1'b0;
        if (g == 0) q0.delete(); else q1.delete();
      end else begin
        mon_bl = (g == 0) ? 4 : 1;
        if (rd_en[g]) check("rd_while_empty", !f_empty[g], 32'(f_empty[g]), 32'd0);
        check("credit", (occ[g] + int'(rd_en[g])) <= 3, 32'(occ[g] + int'(rd_en[g])), 32'd3);
        if (prev_stall[g]) begin
          check_eq("stall_valid", 32'(m_valid[g]), 32'd1);
          check_eq("stall_data", m_data[g], prev_data[g]);
          check_eq("stall_last", 32'(m_last[g]), 32'(prev_last[g]));
        end
        if (m_valid[g] && m_ready_s[g]) begin
          if (qsize(g) == 0) begin
            check("unexpected_beat", 1'b0, m_data[g], 32'd0);
          end else begin
            mon_exp = (g == 0) ? q0.pop_front() : q1.pop_front();
            check_eq("beat_data", m_data[g], mon_exp);
          end
          mon_last = (beat_idx[g] % mon_bl) == (mon_bl - 1);
          check_eq("beat_last", 32'(m_last[g]), 32'(mon_last));
          beat_idx[g]++;
          if (m_last[g]) last_cnt[g]++;
        end
        occ[g] = occ[g] + int'(rd_en[g]) - int'(m_valid[g] && m_ready_s[g]);
        prev_stall[g] = m_valid[g] && !m_ready_s[g];
        prev_data[g]  = m_data[g];
        prev_last[g]  = m_last[g];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input int g, input logic [31:0] d);
    w_en[g]   = 1'b1;
    w_data[g] = d;
    if (g == 0) q0.push_back(d); else q1.push_back(d);
    tick();
    w_en[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input bit need_q, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy[g] && !(need_q && qsize(g) != 0)) done = 1'b1;
    end
    check("drain_timeout", done, 32'(done), 32'd1);
    tick();
  endtask

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      1:       return (k % 2) == 0;
      2:       return (k % 3) == 0;
      default: return 1'b1;
    endcase
  endfunction

  typedef struct {
    int          n;
    int          mode;
    logic [31:0] base;
    logic [31:0] exp_count;
    int          exp_lasts;
  } vec_t;

  vec_t vecs [5];
  int   reads;
  int   l0;
  int   k;
  bit   found;
  bit   done;

  initial begin
    // beat_count starts at 28 (burst phase 0) when the table runs.
    vecs[0] = '{5, 0, 32'h100, 32'd33, 1};
    vecs[1] = '{3, 1, 32'h200, 32'd36, 1};
    vecs[2] = '{7, 2, 32'h300, 32'd43, 1};
    vecs[3] = '{1, 1, 32'h400, 32'd44, 1};
    vecs[4] = '{8, 2, 32'h500, 32'd52, 2};

    rst_n = 1'b0; en_s = '0; m_ready_s = '0; w_en = '0; w_data = '0;
    #12;
    check_eq("rst_valid", 32'(m_valid[0]), 32'd0);
    check_eq("rst_data", m_data[0], 32'd0);
    check_eq("rst_last", 32'(m_last[0]), 32'd0);
    check_eq("rst_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_rd_en", 32'(rd_en[0]), 32'd0);
    check_eq("rst_cs", 32'(cs[0]), 32'd0);
    check_eq("rst_beat_count", beat_count[0], 32'd0);
    check_eq("rst_valid1", 32'(m_valid[1]), 32'd0);
    check_eq("rst_busy1", 32'(busy[1]), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full-rate stream: two-cycle latency then 8 back-to-back beats.
    m_ready_s[0] = 1'b1;
    for (int i = 0; i < 8; i++) fifo_write(0, 32'h10 + 32'(i));
    en_s[0] = 1'b1;
    @(negedge clk);
    check_eq("lat_rd_en", 32'(rd_en[0]), 32'd1);
    check_eq("lat_cs", 32'(cs[0]), 32'd1);
    check_eq("lat_valid_t0", 32'(m_valid[0]), 32'd0);
    tick();
    @(negedge clk);
    check_eq("lat_valid_t1", 32'(m_valid[0]), 32'd0);
    tick();
    @(negedge clk);
    check_eq("lat_first_data", m_data[0], 32'h10);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check_eq("stream_valid", 32'(m_valid[0]), 32'd1);
      tick();
    end
    @(negedge clk);
    check_eq("t1_busy", 32'(busy[0]), 32'd0);
    check_eq("t1_beat_count", beat_count[0], 32'd8);
    tick();

    // Sink stalled: reads stop at the 3-entry credit, head held.
    m_ready_s[0] = 1'b0; en_s[0] = 1'b0;
    for (int i = 0; i < 8; i++) fifo_write(0, 32'h10 + 32'(i));
    en_s[0] = 1'b1;
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reads += int'(rd_en[0]);
      tick();
    end
    check_eq("t2_reads", 32'(reads), 32'd3);
    @(negedge clk);
    check_eq("t2_rd_en", 32'(rd_en[0]), 32'd0);
    check_eq("t2_valid", 32'(m_valid[0]), 32'd1);
    check_eq("t2_head", m_data[0], 32'h10);
    tick();
    m_ready_s[0] = 1'b1;
    wait_idle(0, 1'b1, 100);
    check_eq("t2_beat_count", beat_count[0], 32'd16);

    // Toggling ready while words trickle in.
    for (int i = 0; i < 12; i++) begin
      m_ready_s[0] = rdy(1, i);
      fifo_write(0, 32'h30 + 32'(i));
    end
    m_ready_s[0] = 1'b1;
    wait_idle(0, 1'b1, 100);
    check_eq("t3_beat_count", beat_count[0], 32'd28);

    for (int e = 0; e < 5; e++) begin
      k = 0;
      l0 = last_cnt[0];
      done = 1'b0;
      for (int i = 0; i < vecs[e].n; i++) begin
        m_ready_s[0] = rdy(vecs[e].mode, k);
        k++;
        fifo_write(0, vecs[e].base + 32'(i));
      end
      for (int c = 0; c < 100 && !done; c++) begin
        m_ready_s[0] = rdy(vecs[e].mode, k);
        k++;
        @(negedge clk);
        if (q0.size() == 0 && !busy[0]) done = 1'b1;
        tick();
      end
      check("vec_drain_timeout", done, 32'(done), 32'd1);
      check_eq("vec_beat_count", beat_count[0], vecs[e].exp_count);
      check_eq("vec_lasts", 32'(last_cnt[0] - l0), 32'(vecs[e].exp_lasts));
      m_ready_s[0] = 1'b1;
    end

    // en dropped after 2 accepted beats: in-flight reads drain, then no reads.
    l0 = last_cnt[0];
    en_s[0] = 1'b0;
    for (int i = 0; i < 8; i++) fifo_write(0, 32'h40 + 32'(i));
    en_s[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (beat_count[0] == 32'd54) found = 1'b1;
    end
    check("t4_two_beats_timeout", found, 32'(found), 32'd1);
    tick();
    en_s[0] = 1'b0;
    wait_idle(0, 1'b0, 50);
    check_eq("t4_drained_count", beat_count[0], 32'd57);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t4_no_rd", 32'(rd_en[0]), 32'd0);
      check_eq("t4_fifo_holds", 32'(f_empty[0]), 32'd0);
      tick();
    end
    en_s[0] = 1'b1;
    wait_idle(0, 1'b1, 100);
    check_eq("t4_beat_count", beat_count[0], 32'd60);
    check_eq("t4_lasts", 32'(last_cnt[0] - l0), 32'd2);

    // Reset with two buffered beats and a read in flight.
    m_ready_s[0] = 1'b0; en_s[0] = 1'b0;
    for (int i = 0; i < 8; i++) fifo_write(0, 32'h50 + 32'(i));
    en_s[0] = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    check_eq("t5_pre_valid", 32'(m_valid[0]), 32'd1);
    check_eq("t5_pre_rd_en", 32'(rd_en[0]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(m_valid[0]), 32'd0);
    check_eq("t5_rst_busy", 32'(busy[0]), 32'd0);
    check_eq("t5_rst_data", m_data[0], 32'd0);
    check_eq("t5_rst_count", beat_count[0], 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    m_ready_s[0] = 1'b1;
    for (int i = 0; i < 6; i++) fifo_write(0, 32'h60 + 32'(i));
    wait_idle(0, 1'b1, 100);
    check_eq("t5_beat_count", beat_count[0], 32'd6);
    check_eq("t5_lasts", 32'(last_cnt[0]), 32'd1);

    // BURST_LEN=1: every beat is last; beat_count wraps.
    en_s[1] = 1'b1; m_ready_s[1] = 1'b1;
    for (int i = 0; i < 3; i++) fifo_write(1, 32'h70 + 32'(i));
    wait_idle(1, 1'b1, 100);
    check_eq("t6_beat_count", beat_count[1], 32'd3);
    check_eq("t6_lasts", 32'(last_cnt[1]), 32'd3);
    force dut1.beat_count_q = 32'hFFFF_FFFE;
    #1;
    release dut1.beat_count_q;
    @(negedge clk);
    check_eq("t6_preload", beat_count[1], 32'hFFFF_FFFE);
    tick();
    for (int i = 0; i < 3; i++) fifo_write(1, 32'h80 + 32'(i));
    wait_idle(1, 1'b1, 100);
    check_eq("t6_wrap", beat_count[1], 32'h0000_0001);
    check_eq("t6_lasts_wrap", 32'(last_cnt[1]), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
